turn_controller: RTL and testbench

//  Subtract-Square game sequencer sitting directly downstream of the 30-second timer.
//  - Consumes the timer's time_up and drives the timer's reset and frequency select.
//  - Holds the pile, alternates players, validates moves and declares the winner.
//  - Rule: the player who removes the last token wins.

---
 rtl/turn_controller_pkg.sv | 21 ++
 rtl/turn_controller_expiry_detect.sv | 41 ++++
 rtl/turn_controller.sv | 169 ++++++++++++++++
 tb/tb_turn_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// turn_controller_pkg: shared encodings for the Subtract-Square turn controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding (S_IDLE/S_ARM/S_PLAY/S_OVER), timer frequency
// codes (FREQ_SLOW/FREQ_FAST/FREQ_STOP) and the default pile width.
package turn_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [1:0] FREQ_SLOW = 2'b00;
  localparam logic [1:0] FREQ_FAST = 2'b11;
  localparam logic [1:0] FREQ_STOP = 2'b01;

  localparam int PILE_W_DEF = 7;

endpackage

// File: rtl/turn_controller_expiry_detect.sv
// turn_controller_expiry_detect: turns the timer's time_up level into an expiry pulse.
// Latency: o_expire is combinational on the cycle time_up is first seen high after arming.
// Backpressure: none; the pulse is offered once and not held.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset (clears armed)
//   i_arm_clr  clears armed (asserted while the controller is in ARM)
//   i_play     controller is in PLAY; arming is only allowed here
//   i_time_up  timer expiry level
//   o_expire   one-cycle pulse: armed and rising edge of time_up
module turn_controller_expiry_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_arm_clr,
  input  logic i_play,
  input  logic i_time_up,
  output logic o_expire
);

  logic r_time_up_q;
  logic r_armed;

  // The timer holds time_up high while it is being reset, so an edge only
  // counts once time_up has been observed low inside PLAY.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_time_up_q <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_time_up_q <= i_time_up;
      if (i_arm_clr) begin
        r_armed <= 1'b0;
      end else if (i_play && !i_time_up) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_expire = r_armed && i_time_up && !r_time_up_q;

endmodule

// File: rtl/turn_controller.sv
// turn_controller: Subtract-Square game sequencer driving the 30-second timer.
// Latency: a move or expiry sampled on cycle N is reflected on the outputs at N+1.
// Backpressure: none; moves outside PLAY are dropped, rejected moves pulse illegal.
// Ports:
//   clk, reset_n (synchronous, active-HIGH despite the name)
//   start, move_valid, move_root[2:0], time_up            inputs
//   timer_reset, frequency[1:0], pile, player, illegal,
//   winner_valid, winner                                   registered outputs
// Optional feature macro TURN_AUTOMOVE_EN: expiry becomes a forced root-1 move
// and the next player runs on the fast timer until they make a legal move.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int PILE_W    = PILE_W_DEF,
  parameter int PILE_INIT = 30,
  parameter int MAX_ROOT  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              move_valid,
  input  logic [2:0]        move_root,
  input  logic              time_up,
  output logic              timer_reset,
  output logic [1:0]        frequency,
  output logic [PILE_W-1:0] pile,
  output logic              player,
  output logic              illegal,
  output logic              winner_valid,
  output logic              winner
);

  state_t            r_state, w_state_nxt;
  logic [PILE_W-1:0] r_pile, w_pile_nxt;
  logic              r_player, w_player_nxt;
  logic              r_illegal, w_illegal_nxt;
  logic              r_winner_valid, w_winner_valid_nxt;
  logic              r_winner, w_winner_nxt;
`ifdef TURN_AUTOMOVE_EN
  logic              r_fast, w_fast_nxt;
`endif

  logic              w_expire;
  logic [PILE_W:0]   w_sq;
  logic              w_root_ok;
  logic              w_legal;
  logic              w_apply;
  logic [PILE_W-1:0] w_take;
  logic [PILE_W-1:0] w_left;

  turn_controller_expiry_detect u_expiry (
    .i_clk     (clk),
    .i_reset   (reset_n),
    .i_arm_clr (r_state == S_ARM),
    .i_play    (r_state == S_PLAY),
    .i_time_up (time_up),
    .o_expire  (w_expire)
  );

  // One extra bit so 7*7 cannot wrap before the compare against the pile.
  assign w_sq      = (PILE_W+1)'(move_root) * (PILE_W+1)'(move_root);
  assign w_root_ok = (move_root != 3'd0) && (move_root <= 3'(MAX_ROOT));
  assign w_legal   = (r_state == S_PLAY) && move_valid && w_root_ok &&
                     (w_sq <= {1'b0, r_pile});

`ifdef TURN_AUTOMOVE_EN
  // A legal move takes priority; otherwise an expiry removes a single token.
  assign w_apply = w_legal || w_expire;
  assign w_take  = w_legal ? w_sq[PILE_W-1:0] : PILE_W'(1);
`else
  assign w_apply = w_legal;
  assign w_take  = w_sq[PILE_W-1:0];
`endif
  assign w_left = r_pile - w_take;

  always_comb begin
    w_state_nxt        = r_state;
    w_pile_nxt         = r_pile;
    w_player_nxt       = r_player;
    w_illegal_nxt      = 1'b0;
    w_winner_valid_nxt = r_winner_valid;
    w_winner_nxt       = r_winner;
`ifdef TURN_AUTOMOVE_EN
    w_fast_nxt         = r_fast;
`endif
    case (r_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          w_pile_nxt         = PILE_W'(PILE_INIT);
          w_player_nxt       = 1'b0;
          w_winner_valid_nxt = 1'b0;
          w_state_nxt        = S_ARM;
`ifdef TURN_AUTOMOVE_EN
          w_fast_nxt         = 1'b0;
`endif
        end
      end
      S_ARM: w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (move_valid && !w_legal) begin
          w_illegal_nxt = 1'b1;
        end
        if (w_apply) begin
          w_pile_nxt = w_left;
          if (w_left == '0) begin
            w_winner_nxt       = r_player;
            w_winner_valid_nxt = 1'b1;
            w_state_nxt        = S_OVER;
          end else begin
            w_player_nxt = ~r_player;
            w_state_nxt  = S_ARM;
          end
`ifdef TURN_AUTOMOVE_EN
          w_fast_nxt = !w_legal;
`endif
        end
`ifndef TURN_AUTOMOVE_EN
        else if (w_expire) begin
          w_winner_nxt       = ~r_player;
          w_winner_valid_nxt = 1'b1;
          w_state_nxt        = S_OVER;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state        <= S_IDLE;
      r_pile         <= PILE_W'(PILE_INIT);
      r_player       <= 1'b0;
      r_illegal      <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= 1'b0;
`ifdef TURN_AUTOMOVE_EN
      r_fast         <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_pile         <= w_pile_nxt;
      r_player       <= w_player_nxt;
      r_illegal      <= w_illegal_nxt;
      r_winner_valid <= w_winner_valid_nxt;
      r_winner       <= w_winner_nxt;
`ifdef TURN_AUTOMOVE_EN
      r_fast         <= w_fast_nxt;
`endif
    end
  end

  // Timer controls decode straight from the state register. ARM already shows
  // the speed the upcoming turn will run at; the timer is held in reset there.
  assign timer_reset = (r_state != S_PLAY);
`ifdef TURN_AUTOMOVE_EN
  assign frequency = ((r_state == S_PLAY) || (r_state == S_ARM)) ?
                     (r_fast ? FREQ_FAST : FREQ_SLOW) : FREQ_STOP;
`else
  assign frequency = ((r_state == S_PLAY) || (r_state == S_ARM)) ? FREQ_SLOW : FREQ_STOP;
`endif

  assign pile         = r_pile;
  assign player       = r_player;
  assign illegal      = r_illegal;
  assign winner_valid = r_winner_valid;
  assign winner       = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed self-checking bench for turn_controller.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_turn_controller;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       move_valid;
  logic [2:0] move_root;
  logic       time_up;
  logic       timer_reset;
  logic [1:0] frequency;
  logic [6:0] pile;
  logic       player;
  logic       illegal;
  logic       winner_valid;
  logic       winner;

  int checks = 0;
  int errors = 0;

  turn_controller #(.PILE_W(7), .PILE_INIT(30), .MAX_ROOT(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .move_valid   (move_valid),
    .move_root    (move_root),
    .time_up      (time_up),
    .timer_reset  (timer_reset),
    .frequency    (frequency),
    .pile         (pile),
    .player       (player),
    .illegal      (illegal),
    .winner_valid (winner_valid),
    .winner       (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the first PLAY cycle of the new game.
  task automatic start_game;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
  endtask

  // Returns one cycle after the move was sampled.
  task automatic send_move(input logic [2:0] r);
    @(negedge clk);
    move_valid = 1'b1;
    move_root  = r;
    @(negedge clk) move_valid = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) reset_n = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (pile !== 7'd30) begin errors++; $display("FAIL reset_pile: got %0d expected 30", pile); end
    checks++; if (player !== 1'b0) begin errors++; $display("FAIL reset_player: got %0d expected 0", player); end
    checks++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL reset_timer_reset: got %0d expected 1", timer_reset); end
    checks++; if (frequency !== 2'b01) begin errors++; $display("FAIL reset_frequency: got %b expected 01", frequency); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL reset_winner_valid: got %0d expected 0", winner_valid); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0d expected 0", illegal); end
  endtask

  task automatic test_midplay_reset;
    start_game;
    send_move(3'd3);
    send_move(3'd3);
    checks++; if (pile !== 7'd12) begin errors++; $display("FAIL midplay_pile12: got %0d expected 12", pile); end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pile !== 7'd30) begin errors++; $display("FAIL midreset_pile: got %0d expected 30", pile); end
    checks++; if (player !== 1'b0) begin errors++; $display("FAIL midreset_player: got %0d expected 0", player); end
    checks++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL midreset_timer_reset: got %0d expected 1", timer_reset); end
    checks++; if (frequency !== 2'b01) begin errors++; $display("FAIL midreset_frequency: got %b expected 01", frequency); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL midreset_winner_valid: got %0d expected 0", winner_valid); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL idle_after_reset: got timer_reset %0d expected 1", timer_reset); end
  endtask

  task automatic test_move;
    start_game;
    checks++; if (timer_reset !== 1'b0) begin errors++; $display("FAIL play_timer_reset: got %0d expected 0", timer_reset); end
    send_move(3'd5);
    checks++; if (pile !== 7'd5) begin errors++; $display("FAIL move5_pile: got %0d expected 5", pile); end
    checks++; if (player !== 1'b1) begin errors++; $display("FAIL move5_player: got %0d expected 1", player); end
    checks++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL move5_arm_timer_reset: got %0d expected 1", timer_reset); end
    @(negedge clk);
    checks++; if (timer_reset !== 1'b0) begin errors++; $display("FAIL move5_play_timer_reset: got %0d expected 0", timer_reset); end
    checks++; if (frequency !== 2'b00) begin errors++; $display("FAIL move5_frequency: got %b expected 00", frequency); end
  endtask

  task automatic test_illegal;
    logic [2:0] roots [3];
    roots = '{3'd3, 3'd0, 3'd6};
    foreach (roots[i]) begin
      send_move(roots[i]);
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse_r%0d: got %0d expected 1", roots[i], illegal); end
      checks++; if (pile !== 7'd5) begin errors++; $display("FAIL illegal_pile_r%0d: got %0d expected 5", roots[i], pile); end
      checks++; if (player !== 1'b1) begin errors++; $display("FAIL illegal_player_r%0d: got %0d expected 1", roots[i], player); end
      checks++; if (timer_reset !== 1'b0) begin errors++; $display("FAIL illegal_state_r%0d: got timer_reset %0d expected 0", roots[i], timer_reset); end
      @(negedge clk);
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_width_r%0d: got %0d expected 0", roots[i], illegal); end
    end
    // start is ignored during PLAY
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (pile !== 7'd5 || timer_reset !== 1'b0) begin errors++; $display("FAIL start_in_play: got pile %0d timer_reset %0d expected 5 0", pile, timer_reset); end
  endtask

  task automatic test_win;
    do_reset;
    start_game;
    send_move(3'd4);   // 30 -> 14, player 1
    send_move(3'd3);   // 14 -> 5,  player 0
    send_move(3'd1);   // 5  -> 4,  player 1
    checks++; if (pile !== 7'd4 || player !== 1'b1) begin errors++; $display("FAIL win_setup: got pile %0d player %0d expected 4 1", pile, player); end
    send_move(3'd2);
    checks++; if (pile !== 7'd0) begin errors++; $display("FAIL win_pile: got %0d expected 0", pile); end
    checks++; if (winner_valid !== 1'b1) begin errors++; $display("FAIL win_valid: got %0d expected 1", winner_valid); end
    checks++; if (winner !== 1'b1) begin errors++; $display("FAIL win_winner: got %0d expected 1", winner); end
    checks++; if (frequency !== 2'b01) begin errors++; $display("FAIL win_frequency: got %b expected 01", frequency); end
    checks++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL win_timer_reset: got %0d expected 1", timer_reset); end
    // moves in GAME_OVER are dropped silently
    send_move(3'd1);
    checks++; if (illegal !== 1'b0 || pile !== 7'd0 || winner !== 1'b1) begin errors++; $display("FAIL over_move_ignored: got illegal %0d pile %0d winner %0d expected 0 0 1", illegal, pile, winner); end
    start_game;
    checks++; if (pile !== 7'd30 || player !== 1'b0) begin errors++; $display("FAIL restart: got pile %0d player %0d expected 30 0", pile, player); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL restart_winner_valid: got %0d expected 0", winner_valid); end
  endtask

  task automatic test_expiry;
    do_reset;
    time_up = 1'b1;
    start_game;
    repeat (4) @(negedge clk);
    checks++; if (winner_valid !== 1'b0 || pile !== 7'd30 || timer_reset !== 1'b0) begin errors++; $display("FAIL no_early_expiry: got wv %0d pile %0d timer_reset %0d expected 0 30 0", winner_valid, pile, timer_reset); end
    time_up = 1'b0;
    repeat (2) @(negedge clk);
    time_up = 1'b1;
    @(negedge clk);
`ifdef TURN_AUTOMOVE_EN
    checks++; if (pile !== 7'd29 || player !== 1'b1) begin errors++; $display("FAIL automove: got pile %0d player %0d expected 29 1", pile, player); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL automove_wv: got %0d expected 0", winner_valid); end
    @(negedge clk);
    checks++; if (frequency !== 2'b11) begin errors++; $display("FAIL automove_fast: got %b expected 11", frequency); end
    send_move(3'd1);
    @(negedge clk);
    checks++; if (frequency !== 2'b00 || pile !== 7'd28) begin errors++; $display("FAIL automove_slow_again: got freq %b pile %0d expected 00 28", frequency, pile); end
`else
    checks++; if (winner_valid !== 1'b1) begin errors++; $display("FAIL forfeit_valid: got %0d expected 1", winner_valid); end
    checks++; if (winner !== 1'b1) begin errors++; $display("FAIL forfeit_winner: got %0d expected 1", winner); end
    checks++; if (pile !== 7'd30 || frequency !== 2'b01) begin errors++; $display("FAIL forfeit_hold: got pile %0d freq %b expected 30 01", pile, frequency); end
`endif
  endtask

  task automatic test_same_cycle;
    do_reset;
    time_up = 1'b1;
    start_game;
    @(negedge clk) time_up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    time_up    = 1'b1;
    move_valid = 1'b1;
    move_root  = 3'd1;
    @(negedge clk) move_valid = 1'b0;
    checks++; if (pile !== 7'd29 || player !== 1'b1) begin errors++; $display("FAIL same_cycle_move: got pile %0d player %0d expected 29 1", pile, player); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_no_forfeit: got %0d expected 0", winner_valid); end
    repeat (3) @(negedge clk);
    checks++; if (frequency !== 2'b00 || pile !== 7'd29 || winner_valid !== 1'b0) begin errors++; $display("FAIL same_cycle_after: got freq %b pile %0d wv %0d expected 00 29 0", frequency, pile, winner_valid); end
  endtask

  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    move_valid = 1'b0;
    move_root  = 3'd0;
    time_up    = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    test_reset;
    test_midplay_reset;
    test_move;
    test_illegal;
    test_win;
    test_expiry;
    test_same_cycle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
